// File: rtl/ysyx_22040759_rf_sb.sv
// Multi-ported integer register file with a per-register pending scoreboard.
// Two writeback ports (ALU on port 0, LSU on port 1; port 1 wins on a collision).
// NRD combinational read ports with optional same-cycle write forwarding.
// One issue-time allocation port marks a destination register as pending.
// Register 0 is hardwired to zero and is never marked pending.
module ysyx_22040759_rf_sb #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wen0,
  input  logic [AW-1:0]       waddr0,
  input  logic [XLEN-1:0]     wdata0,
  input  logic                wen1,
  input  logic [AW-1:0]       waddr1,
  input  logic [XLEN-1:0]     wdata1,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  output logic [AW:0]         busy_cnt,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);

  // Number of set bits; bit 0 is never set, so the result fits in AW+1 bits.
  function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) begin
      c = c + {{AW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [AW:0]     busy_cnt_q;
  logic [AW:0]     busy_cnt_d;

  logic w0_hit_s;
  logic w1_hit_s;
  logic alloc_hit_s;

  assign w0_hit_s    = wen0 && (waddr0 != '0);
  assign w1_hit_s    = wen1 && (waddr1 != '0);
  assign alloc_hit_s = alloc_en && (alloc_addr != '0);

  // Next register contents and pending bits; a new producer's alloc outranks a same-cycle write clear.
  always_comb begin
    regs_d    = regs_q;
    busy_d    = busy_q;
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      if (w1_hit_s && (waddr1 == AW'(i))) begin
        regs_d[i] = wdata1;
      end else if (w0_hit_s && (waddr0 == AW'(i))) begin
        regs_d[i] = wdata0;
      end else begin
        regs_d[i] = regs_q[i];
      end
      if (alloc_hit_s && (alloc_addr == AW'(i))) begin
        busy_d[i] = 1'b1;
      end else if ((w0_hit_s && (waddr0 == AW'(i))) || (w1_hit_s && (waddr1 == AW'(i)))) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
    busy_cnt_d = popcount(busy_d);
  end

  // State update; reset clears everything and overrides any same-cycle write or alloc.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   ra_s;
    logic            fwd0_s;
    logic            fwd1_s;
    logic [XLEN-1:0] rd_s;
    logic            rb_s;

    assign ra_s   = raddr[p*AW +: AW];
    assign fwd0_s = (BYPASS != 0) && w0_hit_s && (waddr0 == ra_s);
    assign fwd1_s = (BYPASS != 0) && w1_hit_s && (waddr1 == ra_s);

    // Read mux: zero register, then forwarded write data (port 1 first), then stored value.
    always_comb begin
      if (rst || (ra_s == '0)) begin
        rd_s = '0;
        rb_s = 1'b0;
      end else if (fwd1_s) begin
        rd_s = wdata1;
        rb_s = 1'b0;
      end else if (fwd0_s) begin
        rd_s = wdata0;
        rb_s = 1'b0;
      end else begin
        rd_s = regs_q[ra_s];
        rb_s = busy_q[ra_s];
      end
    end

    assign rdata[p*XLEN +: XLEN] = rd_s;
    assign rbusy[p]              = rb_s;
  end

  // Debug peek of stored state, deliberately bypassing forwarding.
  always_comb begin
    if (rst) begin
      dbg_data = '0;
    end else begin
      dbg_data = regs_q[dbg_addr];
    end
  end

endmodule

// File: doc/ysyx_22040759_rf_sb.md
YSYX_22040759_RF_SB -- requirements
Module: ysyx_22040759_rf_sb

Interface
REQ-001 SHALL provide parameter XLEN, default 64, data width of each register.
REQ-002 SHALL provide parameter NREG, default 32, register count (power of two, 2..64); AW = clog2(NREG).
REQ-003 SHALL provide parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL provide parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-005 SHALL have port clk  in  1  the single clock, all state updates on its rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports wen0/waddr0/wdata0  in  1/AW/XLEN  write port 0 (ALU writeback).
REQ-008 SHALL have ports wen1/waddr1/wdata1  in  1/AW/XLEN  write port 1 (LSU writeback).
REQ-009 SHALL have ports alloc_en/alloc_addr  in  1/AW  mark destination register pending at issue.
REQ-010 SHALL have port raddr  in  NRD*AW  flattened read addresses, port i at [i*AW +: AW].
REQ-011 SHALL have port rdata  out  NRD*XLEN  flattened read data, port i at [i*XLEN +: XLEN].
REQ-012 SHALL have port rbusy  out  NRD  per-port flag: operand still pending.
REQ-013 SHALL have port busy_cnt  out  AW+1  number of pending registers.
REQ-014 SHALL have ports dbg_addr/dbg_data  in AW/out XLEN  simulation-only register peek, no forwarding.

Function
REQ-015 SHALL hold registers 1..NREG-1 as state; register 0 SHALL read as 0 and never be written or marked busy.
REQ-016 SHALL write wdataK to waddrK at clock edge when wenK=1 and waddrK!=0.
REQ-017 SHALL, when both write ports target the same non-zero address in one cycle, store wdata1 (port 1 wins).
REQ-018 SHALL produce rdata combinationally: 0 for address 0; if BYPASS=1 and an enabled write port hits the address this cycle, that port's data (port 1 priority); else stored value.
REQ-019 SHALL keep a busy bit per register: alloc_en with alloc_addr!=0 sets it; any enabled write to that address clears it.
REQ-020 SHALL, when alloc and a write hit the same address in one cycle, leave the busy bit set (new producer wins).
REQ-021 SHALL, when alloc targets an already-busy register, keep it busy and leave busy_cnt unchanged.
REQ-022 SHALL drive rbusy[i] = busy[raddr_i], forced 0 for address 0, and forced 0 when BYPASS=1 and a write hits raddr_i this cycle.
REQ-023 SHALL update busy_cnt registered, next value = popcount of next busy vector; range 0..NREG-1, no wrap.
REQ-024 SHALL ignore writes and clears to non-busy registers for busy_cnt (no underflow).
REQ-025 SHALL drive dbg_data = stored value of dbg_addr (0 for address 0), combinational.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, clear all registers, all busy bits and busy_cnt to 0; rst overrides simultaneous writes and alloc.
REQ-027 SHALL force rdata, rbusy and dbg_data to 0 while rst=1.
REQ-028 SHALL after reset release read 0 on every port, rbusy=0, busy_cnt=0.

Verification
REQ-029 SHALL pass: reset, write x5=0x1234 via port 0, next cycle read raddr0=5 -> rdata0=0x1234, rbusy0=0.
REQ-030 SHALL pass: same cycle wen0 x7=0xAA and wen1 x7=0xBB -> next cycle x7=0xBB; with BYPASS=1 same-cycle read of x7 -> 0xBB.
REQ-031 SHALL pass: alloc x3, then read x3 -> rbusy=1, busy_cnt=1; wen1 x3=0x55 (BYPASS=1) -> same cycle rdata=0x55, rbusy=0; next cycle busy_cnt=0.
REQ-032 SHALL pass: alloc x4 and wen0 x4 same cycle -> x4 busy next cycle, busy_cnt=1, stored data = written value.
REQ-033 SHALL pass: write x0=0xFFFF and alloc x0 -> rdata 0, rbusy 0, busy_cnt 0.
REQ-034 SHALL pass: alloc x1..x3 over three cycles (busy_cnt=3), assert rst with wen0 x1=0x9 -> next cycle x1=0, busy_cnt=0, all rbusy 0.
